mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Sequencer/arbiter sharing the single block-wide instruction/data memory port
//  between two requesters: port 0 = instruction-cache refill (read-only), port 1 =
//  data side (read or write-back). Owns the memory strobes and the multi-cycle
//  access timing; requesters see a valid/ready request and a one-cycle response pulse.
// PARAMETERS
//  ADDR_W   32    address width (matches WORD_SIZE)
//  BLK_W    1024  block data width (matches BLOCK_SIZE)
//  MEM_LAT  4     cycles mem_rd/mem_wr held per access; legal range >= 1
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  req0_valid   in   1       icache read request
//  req0_addr    in   ADDR_W  icache block address
//  req0_ready   out  1       port-0 request accepted this cycle
//  resp0_valid  out  1       port-0 read data valid (1-cycle pulse)
//  resp0_data   out  BLK_W   port-0 read data
//  req1_valid   in   1       data-side request
//  req1_we      in   1       1 = write, 0 = read
//  req1_addr    in   ADDR_W  data-side block address
//  req1_wdata   in   BLK_W   write data
//  req1_ready   out  1       port-1 request accepted this cycle
//  resp1_valid  out  1       port-1 completion (read data or write ack), 1-cycle pulse
//  resp1_data   out  BLK_W   port-1 read data; all-zero on write ack
//  mem_addr     out  ADDR_W  memory address
//  mem_rd       out  1       memory read strobe
//  mem_wr       out  1       memory write strobe
//  mem_wdata    out  BLK_W   memory write data
//  mem_rdata    in   BLK_W   memory read data, valid in last strobe cycle
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0; counter 0; last-grant register = port 1.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: if any reqN_valid, grant one port (policy below), reqN_ready=1 that cycle,
//      capture addr/we/wdata, load counter=MEM_LAT-1, go BUSY. Else stay.
//    BUSY: mem_addr = captured addr; mem_rd=~we or mem_wr=we, held constant;
//      counter decrements; at counter==0 register mem_rdata, go DONE.
//    DONE: respN_valid=1 for granted port, respN_data = registered data (0 for write);
//      strobes low; go IDLE unconditionally.
//  - Latency: accept at cycle T -> strobes T+1..T+MEM_LAT -> resp at T+MEM_LAT+1.
//    Next accept earliest T+MEM_LAT+2; throughput 1 access per MEM_LAT+2 cycles.
//  - Handshake: requester holds valid/addr/wdata stable until ready; ready only in IDLE;
//    at most one reqN_ready high per cycle; ready and resp never high in same cycle.
//  - Ungranted requester simply waits; no request is ever dropped or duplicated.
//  - respN_data holds its last value outside the pulse; strobes never both high.
//  - Counter width $clog2(MEM_LAT)+1; MEM_LAT=1 gives a single-cycle strobe.
//  - Reset mid-access: asynchronous clear, strobes drop immediately, no response for
//    the abandoned request; requester must reissue.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous valid, grant the port NOT granted last;
//    last-grant updates on every grant; reset value port 1 so first tie goes to port 0.
//  Not defined: fixed priority, port 1 always wins a tie; last-grant register omitted.
//  Single-requester behaviour identical in both builds.
// TESTING
//  1. MEM_LAT=4, req0 addr 129 alone at T -> req0_ready@T, mem_rd=1 addr=129 T+1..T+4,
//     resp0_valid@T+5 with model data, mem_wr never 1.
//  2. req1 write addr 7 wdata 1024'b11110 -> mem_wr 4 cycles, resp1_valid with data 0;
//     then req1 read addr 7 -> resp1_data == 1024'b11110.
//  3. Both valid every cycle, 4 grants, fixed build -> order 1,1,1,1 (port 0 starved while
//     port 1 valid); RR build -> 0,1,0,1.
//  4. Back-to-back req0 held valid -> accepts exactly MEM_LAT+2 cycles apart, one resp each.
//  5. rst_n low at T+2 of an access -> mem_rd 0 same cycle, no resp0_valid, IDLE after
//     release; reissued request completes normally.
//  6. MEM_LAT=1 -> single strobe cycle, resp at T+2; ready/resp never coincide.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-port bundle between the two requesters, the arbiter and the block memory.
// master = requesters plus memory (environment side), slave = mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 1024
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              resp0_valid;
    logic [BLK_W-1:0]  resp0_data;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [BLK_W-1:0]  req1_wdata;
    logic              req1_ready;
    logic              resp1_valid;
    logic [BLK_W-1:0]  resp1_data;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;

    modport master (
        output req0_valid, req0_addr,
        input  req0_ready, resp0_valid, resp0_data,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_data,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req0_valid, req0_addr,
        output req0_ready, resp0_valid, resp0_data,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_data,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one block memory port between icache refill (port 0) and data side (port 1); ARB_ROUND_ROBIN_EN picks RR tie-break.
// Latency: accept at T, strobes T+1..T+MEM_LAT, one-cycle response pulse at T+MEM_LAT+1.
// Backpressure: reqN_ready only in IDLE; the losing requester holds its request and waits.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLK_W   = 1024,
    parameter int MEM_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic port;
        logic we;
    } req_t;

    state_t           state;
    req_t             cur;
    logic [CNT_W-1:0] cnt;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_we;

`ifdef ARB_ROUND_ROBIN_EN
    // last_gnt = 1 means port 1 won last, so port 0 takes the next tie
    logic last_gnt;
    assign gnt0 = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || last_gnt);
`else
    assign gnt0 = (state == IDLE) && bus.req0_valid && !bus.req1_valid;
`endif
    assign gnt1   = (state == IDLE) && bus.req1_valid && !gnt0;
    assign gnt_we = gnt1 && bus.req1_we;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cur             <= '0;
            cnt             <= '0;
            bus.mem_addr    <= {ADDR_W{1'b0}};
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_wdata   <= {BLK_W{1'b0}};
            bus.resp0_valid <= 1'b0;
            bus.resp0_data  <= {BLK_W{1'b0}};
            bus.resp1_valid <= 1'b0;
            bus.resp1_data  <= {BLK_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt        <= 1'b1;
`endif
        end else begin
            bus.resp0_valid <= 1'b0;
            bus.resp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        cur.port      <= gnt1;
                        cur.we        <= gnt_we;
                        bus.mem_addr  <= gnt1 ? bus.req1_addr : bus.req0_addr;
                        bus.mem_rd    <= !gnt_we;
                        bus.mem_wr    <= gnt_we;
                        bus.mem_wdata <= gnt_we ? bus.req1_wdata : {BLK_W{1'b0}};
                        cnt           <= CNT_W'(MEM_LAT - 1);
`ifdef ARB_ROUND_ROBIN_EN
                        last_gnt      <= gnt1;
`endif
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        // mem_rdata is only guaranteed in the final strobe cycle
                        bus.mem_rd    <= 1'b0;
                        bus.mem_wr    <= 1'b0;
                        bus.mem_addr  <= {ADDR_W{1'b0}};
                        bus.mem_wdata <= {BLK_W{1'b0}};
                        if (cur.port) begin
                            bus.resp1_valid <= 1'b1;
                            bus.resp1_data  <= cur.we ? {BLK_W{1'b0}} : bus.mem_rdata;
                        end else begin
                            bus.resp0_valid <= 1'b1;
                            bus.resp0_data  <= bus.mem_rdata;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
